// File: rtl/br_enc_onehot2bin.sv
// One-hot to binary encoder.
// Produces the bit index of the single set bit of onehot. When more than one
// bit is set, the result is the OR of their indices. Callers are expected to
// guarantee one-hot input.
// Ports:
//   onehot : input  [NumIn-1:0]    one-hot request vector
//   bin    : output [OutWidth-1:0] binary index of the set bit
module br_enc_onehot2bin #(
  parameter int NumIn    = 2,
  parameter int OutWidth = 1
) (
  input  logic [NumIn-1:0]    onehot,
  output logic [OutWidth-1:0] bin
);

  // OR together the indices of every set bit; exactly one contributes for one-hot input
  always_comb begin
    bin = {OutWidth{1'b0}};
    for (int i = 0; i < NumIn; i++) begin
      bin = bin | ({OutWidth{onehot[i]}} & OutWidth'(i));
    end
  end

endmodule

// File: rtl/br_flow_reg_stable_tagged_chk.sv
// Assertion checker for br_flow_reg_stable_tagged.
// Observes the block's interface and flags protocol/stability violations.
// Ports (all inputs):
//   clk, rst_n            : clock and synchronous active-low reset
//   push_valid/push_ready : upstream handshake
//   push_grant            : one-hot grant accompanying push_valid
//   pop_valid/pop_ready   : downstream handshake
//   pop_data/pop_flow_id  : head entry presented downstream
//   occupancy             : number of held entries
module br_flow_reg_stable_tagged_chk #(
  parameter int NumFlows                    = 2,
  parameter int Width                       = 1,
  parameter int IdWidth                     = 1,
  parameter bit EnableCoverPushBackpressure = 1'b1,
  parameter bit EnableAssertFinalNotValid   = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  input logic               push_valid,
  input logic               push_ready,
  input logic [NumFlows-1:0] push_grant,
  input logic               pop_valid,
  input logic               pop_ready,
  input logic [Width-1:0]   pop_data,
  input logic [IdWidth-1:0] pop_flow_id,
  input logic [1:0]         occupancy
);

  if ((NumFlows < 2) || (Width < 1)) begin : g_bad_params
    $error("br_flow_reg_stable_tagged: NumFlows must be >= 2 and Width >= 1");
  end

  a_occupancy_range: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= 2'd2);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    (occupancy == 2'd2) |-> !(push_valid && push_ready));

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    push_valid |-> $onehot(push_grant));

  a_pop_data_known: assert property (@(posedge clk) disable iff (!rst_n)
    pop_valid |-> !$isunknown(pop_data));

  // A stalled pop must keep presenting the same entry until it is taken.
  a_pop_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (pop_valid && !pop_ready) |=>
      (pop_valid && $stable(pop_data) && $stable(pop_flow_id)));

  if (EnableCoverPushBackpressure) begin : g_cover_bp
    c_push_backpressure: cover property (@(posedge clk) disable iff (!rst_n)
      push_valid && !push_ready);
  end

  if (EnableAssertFinalNotValid) begin : g_final_empty
    final begin
      assert (!pop_valid && (occupancy == 2'd0))
        else $error("br_flow_reg_stable_tagged: entries still held at end of test");
    end
  end

endmodule

// File: rtl/br_flow_reg_stable_tagged.sv
// Stable, registered capture stage behind a fixed-priority flow mux.
// Accepts a possibly unstable valid/data stream together with the one-hot
// grant that selected it, buffers up to two entries (head + skid) and
// presents a stable ready/valid pop interface tagged with the binary flow id.
// push_ready depends only on registered state and reset, never on pop_ready,
// so the ready path is broken between consumer and producer.
// Ports:
//   clk          : clock
//   rst_n        : synchronous active-low reset
//   push_ready   : out, space available (state is not full, not in reset)
//   push_valid   : in,  upstream valid (may be unstable)
//   push_data    : in,  upstream payload (may be unstable)
//   push_grant   : in,  one-hot flow grant, meaningful with push_valid
//   pop_ready    : in,  downstream ready
//   pop_valid    : out, an entry is held
//   pop_data     : out, head payload
//   pop_flow_id  : out, head flow index
//   occupancy    : out, entries held (0..2)
module br_flow_reg_stable_tagged #(
  parameter int NumFlows                    = 2,
  parameter int Width                       = 1,
  parameter bit EnableCoverPushBackpressure = 1'b1,
  parameter bit EnableAssertFinalNotValid   = 1'b1,
  localparam int IdWidth                    = $clog2(NumFlows)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                push_ready,
  input  logic                push_valid,
  input  logic [Width-1:0]    push_data,
  input  logic [NumFlows-1:0] push_grant,
  input  logic                pop_ready,
  output logic                pop_valid,
  output logic [Width-1:0]    pop_data,
  output logic [IdWidth-1:0]  pop_flow_id,
  output logic [1:0]          occupancy
);

  localparam int OccWidth = 2;

  // Encoding doubles as the occupancy count.
  typedef enum logic [OccWidth-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_next_s;
  logic [Width-1:0]    head_data_r;
  logic [IdWidth-1:0]  head_id_r;
  logic [Width-1:0]    skid_data_r;
  logic [IdWidth-1:0]  skid_id_r;
  logic [IdWidth-1:0]  push_id_s;
  logic                push_s;
  logic                pop_s;
  logic                head_load_s;
  logic                head_from_skid_s;
  logic                skid_load_s;

  br_enc_onehot2bin #(
    .NumIn    (NumFlows),
    .OutWidth (IdWidth)
  ) u_enc (
    .onehot (push_grant),
    .bin    (push_id_s)
  );

  assign push_ready  = rst_n & (state_r != TWO);
  assign pop_valid   = (state_r != EMPTY);
  assign pop_data    = head_data_r;
  assign pop_flow_id = head_id_r;
  assign occupancy   = state_r;

  assign push_s = push_valid & push_ready;
  assign pop_s  = pop_valid & pop_ready;

  // Next-state selection from the push/pop handshakes
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (push_s) state_next_s = ONE;
        else        state_next_s = EMPTY;
      end
      ONE: begin
        if (push_s && !pop_s)      state_next_s = TWO;
        else if (!push_s && pop_s) state_next_s = EMPTY;
        else                       state_next_s = ONE;
      end
      TWO: begin
        if (pop_s) state_next_s = ONE;
        else       state_next_s = TWO;
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // Storage load enables: a push lands in head when head is free or being
  // popped, otherwise in skid; a pop from full promotes skid into head.
  always_comb begin
    head_load_s      = 1'b0;
    head_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        head_load_s = push_s;
      end
      ONE: begin
        head_load_s = push_s & pop_s;
        skid_load_s = push_s & ~pop_s;
      end
      TWO: begin
        head_from_skid_s = pop_s;
      end
      default: begin
        head_load_s = 1'b0;
      end
    endcase
  end

  // State and entry registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      head_data_r <= {Width{1'b0}};
      head_id_r   <= {IdWidth{1'b0}};
      skid_data_r <= {Width{1'b0}};
      skid_id_r   <= {IdWidth{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (head_load_s) begin
        head_data_r <= push_data;
        head_id_r   <= push_id_s;
      end else if (head_from_skid_s) begin
        head_data_r <= skid_data_r;
        head_id_r   <= skid_id_r;
      end
      if (skid_load_s) begin
        skid_data_r <= push_data;
        skid_id_r   <= push_id_s;
      end
    end
  end

  br_flow_reg_stable_tagged_chk #(
    .NumFlows                    (NumFlows),
    .Width                       (Width),
    .IdWidth                     (IdWidth),
    .EnableCoverPushBackpressure (EnableCoverPushBackpressure),
    .EnableAssertFinalNotValid   (EnableAssertFinalNotValid)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_grant  (push_grant),
    .pop_valid   (pop_valid),
    .pop_ready   (pop_ready),
    .pop_data    (pop_data),
    .pop_flow_id (pop_flow_id),
    .occupancy   (occupancy)
  );

endmodule

// File: tb/tb_br_flow_reg_stable_tagged.sv
// Self-checking bench for br_flow_reg_stable_tagged (NumFlows=4, Width=8).
// Expected behaviour comes from a FIFO model of depth 2 kept in a queue.
module tb_br_flow_reg_stable_tagged;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] id;
  } entry_t;

  logic       clk;
  logic       rst_n;
  logic       push_ready;
  logic       push_valid;
  logic [7:0] push_data;
  logic [3:0] push_grant;
  logic       pop_ready;
  logic       pop_valid;
  logic [7:0] pop_data;
  logic [1:0] pop_flow_id;
  logic [1:0] occupancy;

  int checks = 0;
  int errors = 0;
  entry_t q[$];

  br_flow_reg_stable_tagged #(
    .NumFlows (4),
    .Width    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_ready  (push_ready),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_grant  (push_grant),
    .pop_ready   (pop_ready),
    .pop_valid   (pop_valid),
    .pop_data    (pop_data),
    .pop_flow_id (pop_flow_id),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] grant_index(input logic [3:0] g);
    for (int i = 0; i < 4; i++) begin
      if (g[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  function automatic logic [3:0] rand_grant();
    logic [3:0] g;
    g = 4'b0001 << $urandom_range(0, 3);
    return g;
  endfunction

  // Advance one clock and update the depth-2 FIFO model; returns at negedge.
  task automatic tick();
    int  sz;
    bit  do_push;
    bit  do_pop;
    entry_t e;
    @(posedge clk);
    sz = q.size();
    if (!rst_n) begin
      q.delete();
    end else begin
      do_push = push_valid && (sz < 2);
      do_pop  = pop_ready && (sz > 0);
      e.d  = push_data;
      e.id = grant_index(push_grant);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; push_valid = 1'b1; push_data = 8'h5A;
    push_grant = 4'b0001; pop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL reset_push_ready got %0b want 0", push_ready); end
      checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid got %0b want 0", pop_valid); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    end
    checks++; if (pop_data !== 8'h00 || pop_flow_id !== 2'd0) begin errors++; $display("FAIL reset_pop_payload got %h/%0d want 00/0", pop_data, pop_flow_id); end
    push_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL release_push_ready got %0b want 1", push_ready); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [1:0] exp_id;
    push_valid = 1'b1; push_data = 8'hA5; push_grant = 4'b0100; pop_ready = 1'b1;
    #1;
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL empty_no_forward got %0b want 0", pop_valid); end
    tick();
    checks++; if (pop_valid !== 1'b1 || pop_data !== 8'hA5 || pop_flow_id !== 2'd2) begin
      errors++; $display("FAIL first_push got v=%0b d=%h id=%0d want v=1 d=a5 id=2", pop_valid, pop_data, pop_flow_id);
    end
    for (int i = 0; i < 16; i++) begin
      push_data = 8'(i);
      exp_id = 2'($urandom_range(0, 3));
      push_grant = 4'b0001 << exp_id;
      tick();
      checks++; if (pop_data !== 8'(i) || pop_flow_id !== exp_id || occupancy !== 2'd1 || push_ready !== 1'b1) begin
        errors++; $display("FAIL stream_%0d got d=%h id=%0d occ=%0d rdy=%0b want d=%h id=%0d occ=1 rdy=1", i, pop_data, pop_flow_id, occupancy, push_ready, 8'(i), exp_id);
      end
    end
    push_valid = 1'b0;
    tick();
    checks++; if (occupancy !== 2'd0 || pop_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got occ=%0d v=%0b want 0/0", occupancy, pop_valid); end
  endtask

  task automatic test_fill();
    pop_ready = 1'b0;
    push_valid = 1'b1; push_data = 8'h11; push_grant = 4'b0001;
    tick();
    push_data = 8'h22; push_grant = 4'b1000;
    tick();
    push_valid = 1'b0;
    checks++; if (occupancy !== 2'd2 || push_ready !== 1'b0) begin errors++; $display("FAIL fill got occ=%0d rdy=%0b want 2/0", occupancy, push_ready); end
    checks++; if (pop_data !== 8'h11 || pop_flow_id !== 2'd0) begin errors++; $display("FAIL fill_head got %h/%0d want 11/0", pop_data, pop_flow_id); end
  endtask

  task automatic test_full_noise();
    for (int i = 0; i < 5; i++) begin
      push_valid = 1'($urandom_range(0, 1));
      push_data  = 8'($urandom);
      push_grant = rand_grant();
      tick();
      checks++; if (occupancy !== 2'd2 || pop_data !== 8'h11) begin errors++; $display("FAIL noise_%0d got occ=%0d d=%h want 2/11", i, occupancy, pop_data); end
    end
    push_valid = 1'b0;
  endtask

  task automatic test_stall_stable();
    for (int i = 0; i < 10; i++) begin
      push_data = 8'($urandom);
      push_grant = rand_grant();
      tick();
      checks++; if (pop_valid !== 1'b1 || pop_data !== 8'h11 || pop_flow_id !== 2'd0) begin
        errors++; $display("FAIL stall_%0d got v=%0b d=%h id=%0d want 1/11/0", i, pop_valid, pop_data, pop_flow_id);
      end
    end
  endtask

  task automatic test_full_pop();
    pop_ready = 1'b1;
    push_valid = 1'b1; push_data = 8'h33; push_grant = 4'b0010;
    #1;
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_pop_no_bypass got %0b want 0", push_ready); end
    tick();
    push_valid = 1'b0;
    checks++; if (occupancy !== 2'd1 || pop_data !== 8'h22 || pop_flow_id !== 2'd3) begin
      errors++; $display("FAIL second_pop got occ=%0d d=%h id=%0d want 1/22/3", occupancy, pop_data, pop_flow_id);
    end
    tick();
    checks++; if (occupancy !== 2'd0 || pop_valid !== 1'b0) begin errors++; $display("FAIL full_pop_drain got occ=%0d v=%0b want 0/0", occupancy, pop_valid); end
  endtask

  task automatic test_reset_mid();
    pop_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_valid = 1'b1; push_data = 8'($urandom); push_grant = rand_grant();
      tick();
    end
    push_valid = 1'b0;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL mid_fill got %0d want 2", occupancy); end
    rst_n = 1'b0; pop_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    checks++; if (occupancy !== 2'd0 || pop_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got occ=%0d v=%0b want 0/0", occupancy, pop_valid); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_ghost_%0d got %0b want 0", i, pop_valid); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      push_valid = 1'($urandom_range(0, 1));
      push_data  = 8'($urandom);
      push_grant = rand_grant();
      pop_ready  = ($urandom_range(0, 3) != 0);
      tick();
      checks++; if (occupancy !== 2'(q.size()) || pop_valid !== (q.size() > 0) || push_ready !== (q.size() < 2)) begin
        errors++; $display("FAIL rand_state_%0d got occ=%0d v=%0b rdy=%0b want occ=%0d", i, occupancy, pop_valid, push_ready, q.size());
      end
      if (q.size() > 0) begin
        checks++; if (pop_data !== q[0].d || pop_flow_id !== q[0].id) begin
          errors++; $display("FAIL rand_head_%0d got %h/%0d want %h/%0d", i, pop_data, pop_flow_id, q[0].d, q[0].id);
        end
      end
    end
    push_valid = 1'b0; pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (q.size() > 0) tick();
    end
    checks++; if (occupancy !== 2'd0 || pop_valid !== 1'b0) begin errors++; $display("FAIL rand_drain got occ=%0d v=%0b want 0/0", occupancy, pop_valid); end
  endtask

  initial begin
    rst_n = 1'b0; push_valid = 1'b0; push_data = 8'h00;
    push_grant = 4'b0001; pop_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_fill();
    test_full_noise();
    test_stall_stable();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
